// File: rtl/clint_timer_ctrl.sv
// clint_timer_ctrl
// Machine-timer controller for the CLINT. Divides the core clock down to a
// 1 us tick, keeps the 64-bit mtime counter, applies software writes to
// mtime and registers the machine-timer interrupt (mtime >= mtimecmp).
//
// Optional feature macro: CLINT_TIMER_HALT_EN (adds the 'halt' input).
//
// Ports:
//   clk        in   core clock
//   reset      in   synchronous, active-high reset
//   halt       in   (CLINT_TIMER_HALT_EN only) freeze prescaler and mtime
//   mtimecmp   in   64-bit compare value from the CLINT register block
//   wen_lo     in   load wdata[31:0] into mtime[31:0]
//   wen_hi     in   load wdata[63:32] into mtime[63:32]
//   wdata      in   64-bit write data
//   mtime      out  current timer value
//   tick       out  high in the cycle where mtime increments
//   timer_irq  out  registered level interrupt, mtime >= mtimecmp
module clint_timer_ctrl #(
  parameter int FMAX_MHz = 27
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CLINT_TIMER_HALT_EN
  input  logic        halt,
`endif
  input  logic [63:0] mtimecmp,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [63:0] wdata,
  output logic [63:0] mtime,
  output logic        tick,
  output logic        timer_irq
);

  localparam int            PW   = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
  localparam logic [PW-1:0] PMAX = PW'(FMAX_MHz - 1);

  logic [PW-1:0] pcnt;
  logic          run;
  logic          wr;

`ifdef CLINT_TIMER_HALT_EN
  assign run = ~halt;
`else
  assign run = 1'b1;
`endif

  assign wr   = wen_lo | wen_hi;
  // With FMAX_MHz == 1 the compare is 0 == 0, so tick stays high outside reset.
  assign tick = ~reset & run & (pcnt == PMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt      <= '0;
      mtime     <= '0;
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      if (wr) begin
        // A write restarts the prescaler phase and suppresses the increment;
        // the unselected half holds, so no carry crosses halves here.
        pcnt <= '0;
        if (wen_lo) mtime[31:0]  <= wdata[31:0];
        if (wen_hi) mtime[63:32] <= wdata[63:32];
      end else if (run) begin
        if (tick) begin
          pcnt  <= '0;
          mtime <= mtime + 64'd1;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clint_timer_ctrl.sv
module tb_clint_timer_ctrl;

  localparam int F = 27;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, wl, wh, halt_v;
  logic [63:0] wd, cmp;
  logic [63:0] mtime;
  logic        tick, irq;

  logic        rst1, halt1;
  logic [63:0] mtime1;
  logic        tick1, irq1;

  int passed = 0;
  int total  = 0;

  // reference state: timer value, elapsed cycles within the current 1 us period
  logic [63:0] m_time = '0;
  int          m_phase = 0;
  logic        m_irq = 1'b0;

  always #5 clk = ~clk;

  clint_timer_ctrl #(.FMAX_MHz(F)) dut (
    .clk(clk), .reset(rst),
`ifdef CLINT_TIMER_HALT_EN
    .halt(halt_v),
`endif
    .mtimecmp(cmp), .wen_lo(wl), .wen_hi(wh), .wdata(wd),
    .mtime(mtime), .tick(tick), .timer_irq(irq)
  );

  clint_timer_ctrl #(.FMAX_MHz(1)) dut1 (
    .clk(clk), .reset(rst1),
`ifdef CLINT_TIMER_HALT_EN
    .halt(halt1),
`endif
    .mtimecmp(64'd0), .wen_lo(1'b0), .wen_hi(1'b0), .wdata(64'd0),
    .mtime(mtime1), .tick(tick1), .timer_irq(irq1)
  );

  typedef struct {
    logic        rst, wl, wh;
    logic [63:0] wd, cmp, e_mtime;
    logic        e_tick, e_irq;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input logic r, input logic l, input logic h,
                       input logic [63:0] d, input logic [63:0] c);
    rst = r; wl = l; wh = h; wd = d; cmp = c;
    #1;
  endtask

  // Compare DUT against the reference for this cycle, advance the reference
  // by the rules (write wins, one increment per F elapsed cycles), then clock.
  task automatic step();
    logic et;
    et = !rst && !halt_v && (m_phase == F - 1);
    chk("model_tick", {63'd0, tick}, {63'd0, et});
    chk("model_mtime", mtime, m_time);
    chk("model_irq", {63'd0, irq}, {63'd0, m_irq});
    if (rst) begin
      m_time = '0; m_phase = 0; m_irq = 1'b0;
    end else begin
      m_irq = (m_time >= cmp);
      if (wl || wh) begin
        if (wl) m_time[31:0]  = wd[31:0];
        if (wh) m_time[63:32] = wd[63:32];
        m_phase = 0;
      end else if (!halt_v) begin
        if (m_phase + 1 == F) m_time = m_time + 64'd1;
        m_phase = (m_phase + 1) % F;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] frozen;
    int r;
    rst = 1'b1; wl = 1'b0; wh = 1'b0; wd = '0; cmp = '0; halt_v = 1'b0;
    rst1 = 1'b1; halt1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, ONES, 64'd0, 64'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 64'd0, 64'd0, ONES, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 64'hAAAA_AAAA_0000_1234, 64'd0, ONES, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 64'h0000_0005_BBBB_BBBB, 64'h0000_0004_0000_0000,
                64'hFFFF_FFFF_0000_1234, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 64'd0, 64'h0000_0006_0000_0000,
                64'h0000_0005_0000_1234, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 64'd0, 64'h0000_0006_0000_0000,
                64'h0000_0005_0000_1234, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 64'd0, ONES, 64'h0000_0005_0000_1234, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, ONES,
                64'h0000_0005_0000_1234, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 64'd0, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 64'd0, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst, tbl[i].wl, tbl[i].wh, tbl[i].wd, tbl[i].cmp);
      chk($sformatf("tbl%0d_mtime", i), mtime, tbl[i].e_mtime);
      chk($sformatf("tbl%0d_tick", i), {63'd0, tick}, {63'd0, tbl[i].e_tick});
      chk($sformatf("tbl%0d_irq", i), {63'd0, irq}, {63'd0, tbl[i].e_irq});
      step();
    end

    // free run from reset: ticks at 26 and 53, mtime 1 at 27 and 2 at 54
    apply(1'b1, 1'b0, 1'b0, 64'd0, ONES); step();
    for (int c = 0; c <= 54; c++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES);
      chk($sformatf("run_tick_c%0d", c), {63'd0, tick}, {63'd0, (c == 26 || c == 53)});
      chk($sformatf("run_mtime_c%0d", c), mtime, (c >= 54) ? 64'd2 : (c >= 27) ? 64'd1 : 64'd0);
      chk($sformatf("run_irq_c%0d", c), {63'd0, irq}, 64'd0);
      step();
    end

    // compare: mtime hits 5 at cycle 135, irq one cycle later, cleared by cmp=100
    apply(1'b1, 1'b0, 1'b0, 64'd0, 64'd5); step();
    for (int c = 0; c <= 136; c++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, 64'd5);
      if (c == 134) chk("cmp_mtime_before", mtime, 64'd4);
      if (c == 135) begin
        chk("cmp_mtime_eq5", mtime, 64'd5);
        chk("cmp_irq_not_yet", {63'd0, irq}, 64'd0);
      end
      if (c == 136) chk("cmp_irq_rise", {63'd0, irq}, 64'd1);
      step();
    end
    apply(1'b0, 1'b0, 1'b0, 64'd0, 64'd100);
    chk("cmp_irq_hold", {63'd0, irq}, 64'd1);
    step();
    apply(1'b0, 1'b0, 1'b0, 64'd0, 64'd100);
    chk("cmp_irq_clear", {63'd0, irq}, 64'd0);
    step();

    // wrap: all-ones wraps to zero on the next tick, irq stays high with cmp=0
    apply(1'b0, 1'b1, 1'b1, ONES, 64'd0); step();
    for (int j = 1; j <= 28; j++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      chk($sformatf("wrap_irq_j%0d", j), {63'd0, irq}, 64'd1);
      chk($sformatf("wrap_tick_j%0d", j), {63'd0, tick}, {63'd0, (j == 27)});
      chk($sformatf("wrap_mtime_j%0d", j), mtime, (j == 28) ? 64'd0 : ONES);
      step();
    end

    // split write colliding with a tick: no increment, no carry, phase restarts
    apply(1'b0, 1'b1, 1'b1, 64'h0000_0001_FFFF_FFFF, ONES); step();
    for (int j = 1; j <= 26; j++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES); step();
    end
    apply(1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0000, ONES);
    chk("split_tick_in_write_cycle", {63'd0, tick}, 64'd1);
    step();
    for (int j = 1; j <= 27; j++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES);
      if (j == 1) chk("split_mtime", mtime, 64'h0000_0001_0000_0000);
      chk($sformatf("split_next_tick_j%0d", j), {63'd0, tick}, {63'd0, (j == 27)});
      step();
    end

    // FMAX_MHz=1 instance: tick low in reset, then high every cycle
    chk("f1_tick_in_reset", {63'd0, tick1}, 64'd0);
    chk("f1_mtime_in_reset", mtime1, 64'd0);
    rst1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES);
      chk($sformatf("f1_tick_c%0d", c), {63'd0, tick1}, 64'd1);
      chk($sformatf("f1_mtime_c%0d", c), mtime1, 64'(c));
      step();
    end

`ifdef CLINT_TIMER_HALT_EN
    // halt at phase 10 for 40 cycles, next tick 16 cycles after release
    apply(1'b0, 1'b1, 1'b1, 64'd1000, ONES); step();
    for (int j = 0; j < 10; j++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES); step();
    end
    frozen = mtime;
    halt_v = 1'b1;
    for (int j = 0; j < 40; j++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES);
      chk($sformatf("halt_mtime_j%0d", j), mtime, frozen);
      chk($sformatf("halt_tick_j%0d", j), {63'd0, tick}, 64'd0);
      step();
    end
    halt_v = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      apply(1'b0, 1'b0, 1'b0, 64'd0, ONES);
      chk($sformatf("halt_release_tick_j%0d", j), {63'd0, tick}, {63'd0, (j == 16)});
      step();
    end
`endif

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      logic nr, nl, nh;
      logic [63:0] nd, nc;
      nr = ($urandom_range(0, 299) == 0);
      r  = $urandom_range(0, 15);
      nl = (r == 0 || r == 2);
      nh = (r == 1 || r == 2);
      nd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) nd = ONES - 64'($urandom_range(0, 3));
      nc = cmp;
      case ($urandom_range(0, 7))
        0: nc = {$urandom, $urandom};
        1: nc = m_time + 64'($urandom_range(0, 3));
        2: nc = ONES;
        3: nc = m_time - 64'($urandom_range(0, 2));
        default: ;
      endcase
`ifdef CLINT_TIMER_HALT_EN
      halt_v = ($urandom_range(0, 7) == 0);
`endif
      apply(nr, nl, nh, nd, nc);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
